// File: rtl/acq_sequencer_if.sv
// CPU I/O bus, sample source and buffer RAM port of the acquisition sequencer.
// The master side is the surrounding system; the slave side is the sequencer.
interface acq_sequencer_if;
    logic [15:0] io_addr;
    logic        write_IO;
    logic        read_IO;
    logic [15:0] io_rdata;
    logic        io_rvalid;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic        buf_en;
    logic        buf_we;
    logic [7:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata;
    logic        interrupt;

    modport master (
        output io_addr, write_IO, read_IO, sample_valid, sample_data, buf_rdata,
        input  io_rdata, io_rvalid, buf_en, buf_we, buf_addr, buf_wdata, interrupt
    );

    modport slave (
        input  io_addr, write_IO, read_IO, sample_valid, sample_data, buf_rdata,
        output io_rdata, io_rvalid, buf_en, buf_we, buf_addr, buf_wdata, interrupt
    );
endinterface

// File: rtl/acq_sequencer.sv
// Sequences 256-sample captures into an external 256x8 buffer and arbitrates
// that buffer port between capture writes and CPU reads of the 0x55xx window.
module acq_sequencer #(
    parameter logic [15:0] ADDR_START  = 16'h5000,
    parameter logic [15:0] ADDR_ACK    = 16'h5001,
    parameter logic [15:0] ADDR_STATUS = 16'h5002,
    parameter logic [15:0] BUF_BASE    = 16'h5500
) (
    input  logic          clk,
    input  logic          rst,
    acq_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t      r_state;
    logic [8:0]  r_count;
    logic        r_rd_drop;
    logic        r_pend_v;
    logic [7:0]  r_pend_addr;
    logic        r_rd_s2;
    logic [7:0]  r_rd_a2;
    logic [15:0] r_dq [2];
    logic [1:0]  r_dq_cnt;
    logic        r_buf_en;
    logic        r_buf_we;
    logic [7:0]  r_buf_addr;
    logic [7:0]  r_buf_wdata;
    logic [15:0] r_io_rdata;
    logic        r_io_rvalid;
    logic        r_interrupt;

    logic        w_wr_start;
    logic        w_wr_ack;
    logic        w_in_window;
    logic        w_rd_drop;
    logic        w_rd_buf;
    logic        w_rd_dir;
    logic        w_samp_acc;
    logic        w_rsp_pop;
    logic [15:0] w_dir_data;

    assign w_wr_start  = bus.write_IO && (bus.io_addr == ADDR_START);
    assign w_wr_ack    = bus.write_IO && (bus.io_addr == ADDR_ACK);
    assign w_in_window = (bus.io_addr[15:8] == BUF_BASE[15:8]);
    assign w_rd_drop   = bus.read_IO && r_pend_v;
    assign w_rd_buf    = bus.read_IO && !r_pend_v && w_in_window;
    assign w_rd_dir    = bus.read_IO && !r_pend_v && !w_in_window;
    // An abort on the same edge as a sample wins; that sample is not captured.
    assign w_samp_acc  = (r_state == ST_CAPTURE) && bus.sample_valid && !w_wr_ack;
    assign w_rsp_pop   = !r_rd_s2 && (r_dq_cnt != 2'd0);

    always_comb begin
        w_dir_data = '0;
        if (bus.io_addr == ADDR_STATUS)
            w_dir_data = {r_state, r_rd_drop, 4'b0000, r_count};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_rd_drop   <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= '0;
            r_rd_s2     <= 1'b0;
            r_rd_a2     <= '0;
            r_dq[0]     <= '0;
            r_dq[1]     <= '0;
            r_dq_cnt    <= '0;
            r_buf_en    <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
            r_io_rdata  <= '0;
            r_io_rvalid <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_start) begin
                        r_state <= ST_CAPTURE;
                        r_count <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_wr_ack) begin
                        r_state <= ST_IDLE;
                    end else if (w_samp_acc) begin
                        r_count <= r_count + 9'd1;
                        if (r_count == 9'd255) begin
                            r_state     <= ST_DONE;
                            r_interrupt <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_wr_ack) begin
                        r_state     <= ST_IDLE;
                        r_interrupt <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_rd_drop)
                r_rd_drop <= 1'b1;
            else if ((r_state == ST_IDLE) && w_wr_start)
                r_rd_drop <= 1'b0;

            // Port priority: capture write, then the parked read, then a fresh read.
            if (w_samp_acc) begin
                r_buf_en    <= 1'b1;
                r_buf_we    <= 1'b1;
                r_buf_addr  <= r_count[7:0];
                r_buf_wdata <= bus.sample_data;
                if (w_rd_buf) begin
                    r_pend_v    <= 1'b1;
                    r_pend_addr <= bus.io_addr[7:0];
                end
            end else if (r_pend_v) begin
                r_buf_en    <= 1'b1;
                r_buf_we    <= 1'b0;
                r_buf_addr  <= r_pend_addr;
                r_buf_wdata <= '0;
                r_pend_v    <= 1'b0;
            end else if (w_rd_buf) begin
                r_buf_en    <= 1'b1;
                r_buf_we    <= 1'b0;
                r_buf_addr  <= bus.io_addr[7:0];
                r_buf_wdata <= '0;
            end else begin
                r_buf_en    <= 1'b0;
                r_buf_we    <= 1'b0;
                r_buf_addr  <= '0;
                r_buf_wdata <= '0;
            end

            r_rd_s2 <= r_buf_en && !r_buf_we;
            r_rd_a2 <= r_buf_addr;

            // Buffer responses are fixed-latency so they take the response slot;
            // status/unmapped responses wait in a short queue if they collide.
            if (r_rd_s2) begin
                r_io_rvalid <= 1'b1;
                r_io_rdata  <= {r_rd_a2, bus.buf_rdata};
            end else if (r_dq_cnt != 2'd0) begin
                r_io_rvalid <= 1'b1;
                r_io_rdata  <= r_dq[0];
            end else begin
                r_io_rvalid <= 1'b0;
                r_io_rdata  <= '0;
            end

            case ({w_rd_dir, w_rsp_pop})
                2'b10: begin
                    if (r_dq_cnt == 2'd0)
                        r_dq[0] <= w_dir_data;
                    else
                        r_dq[1] <= w_dir_data;
                    if (r_dq_cnt != 2'd2)
                        r_dq_cnt <= r_dq_cnt + 2'd1;
                end
                2'b01: begin
                    r_dq[0]  <= r_dq[1];
                    r_dq_cnt <= r_dq_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_dq_cnt == 2'd1) begin
                        r_dq[0] <= w_dir_data;
                    end else begin
                        r_dq[0] <= r_dq[1];
                        r_dq[1] <= w_dir_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.buf_en    = r_buf_en;
    assign bus.buf_we    = r_buf_we;
    assign bus.buf_addr  = r_buf_addr;
    assign bus.buf_wdata = r_buf_wdata;
    assign bus.io_rdata  = r_io_rdata;
    assign bus.io_rvalid = r_io_rvalid;
    assign bus.interrupt = r_interrupt;

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Controller for the 256-sample data-collection path. It decodes CPU I/O writes to the start and acknowledge registers and sequences sample capture into an external single-port 256x8 sample buffer. It raises `interrupt` when the buffer is full and arbitrates the buffer port between capture writes and CPU reads in the 0x5500–0x55FF window. It sits between the CPU I/O bus, the sample source and the buffer RAM.

## Interface
- `ADDR_START`, 16'h5000, write here arms a capture
- `ADDR_ACK`, 16'h5001, write here acknowledges/aborts
- `ADDR_STATUS`, 16'h5002, read-only status register
- `BUF_BASE`, 16'h5500, base of 256-byte buffer read window
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `io_addr`  in  16  CPU I/O address
- `write_IO`  in  1  write strobe; one cycle = one write
- `read_IO`  in  1  read strobe; one cycle = one request
- `io_rdata`  out  16  read data, valid when `io_rvalid`
- `io_rvalid`  out  1  one-cycle read response pulse
- `sample_valid`  in  1  sample present on `sample_data` this cycle
- `sample_data`  in  8  sample value
- `buf_en`  out  1  buffer port enable
- `buf_we`  out  1  buffer write enable (qualified by `buf_en`)
- `buf_addr`  out  8  buffer address
- `buf_wdata`  out  8  buffer write data
- `buf_rdata`  in  8  buffer read data, valid the cycle after `buf_en`&!`buf_we`
- `interrupt`  out  1  level, buffer full, held until acknowledged

## Operation
- States: IDLE(0), CAPTURE(1), DONE(2). `count[8:0]`: samples written this capture.
- IDLE:
  - `write_IO` && `io_addr==ADDR_START` -> CAPTURE, `count`<=0.
  - Samples ignored.
- CAPTURE:
  - Each `sample_valid` cycle writes `sample_data` to buffer address `count[7:0]`, then `count`++.
  - The write that makes `count==256` -> DONE, `interrupt`<=1.
  - ACK write -> IDLE (abort). `count` keeps its value, `interrupt` stays 0.
  - START write is ignored.
- DONE:
  - Samples and START are ignored.
  - ACK write -> IDLE, `interrupt`<=0. `count` remains 256 until the next START.
- Simultaneous `write_IO` and `read_IO` in one cycle: both serviced.
- Read decode, registered at request edge:
  - `BUF_BASE..BUF_BASE+255` -> buffer read at `io_addr[7:0]`. Response `io_rdata={io_addr[7:0], buf_rdata}`.
  - `ADDR_STATUS` -> `{state[1:0], rd_drop, 4'b0, count[8:0]}`.
  - Any other address -> `io_rdata=16'h0000`.
  - Every request that is not dropped gets exactly one `io_rvalid` pulse.
- Arbitration on the buffer port:
  - A capture write has absolute priority.
  - A buffer read colliding with an accepted sample is held in a one-entry pending slot and issued on the first cycle with no sample write.
  - Continuous `sample_valid` starves reads until DONE/IDLE.
- Overflow of the pending slot: a new `read_IO` while a read is still pending is dropped (no `io_rvalid`) and sets sticky `rd_drop`.
  - `rd_drop` is cleared by START.
- Buffer reads are legal in every state. Data for unwritten addresses is whatever the RAM holds.

## Timing
- Reset (`rst`=0, async):
  - State IDLE, `count`=0, `rd_drop`=0, pending slot empty.
  - All outputs 0: `buf_en`, `buf_we`, `buf_addr`, `buf_wdata`, `io_rdata`, `io_rvalid`, `interrupt`.
  - Reset mid-capture discards progress; no `io_rvalid` for in-flight reads.
- START at edge N: CAPTURE from N. The first sample accepted is at edge N+1.
- Sample accepted at edge k:
  - `buf_en`=`buf_we`=1 with address/data registered during cycle k..k+1.
  - RAM writes at edge k+1.
- 256th sample accepted at edge k: `interrupt`=1 and state DONE visible after edge k.
- Uncontended buffer read requested at edge k:
  - `buf_en`=1, `buf_we`=0 during k..k+1.
  - `buf_rdata` is sampled at edge k+2.
  - `io_rvalid`=1 for exactly one cycle, k+2..k+3. Latency is 2 cycles.
- Each cycle of buffer-port contention adds 1 cycle of read latency.
- Status and unmapped reads: `io_rvalid` with data, k+1..k+2 (latency 1).
- `buf_en` is asserted only for an actual write or read. Otherwise all `buf_*` outputs return to 0.

## Test plan
- Reset, START, 256 consecutive `sample_valid` with `sample_data`=index:
  - RAM holds 0x00..0xFF.
  - `interrupt` rises exactly after the 256th accepted edge.
  - Status read = 16'h8100.
- Sparse samples (every 3rd cycle) plus ACK after 10 samples:
  - IDLE, `interrupt`=0, status = 16'h000A.
  - Later samples are not written.
- In DONE, read 0x5505:
  - `io_rvalid` exactly 2 cycles after request.
  - `io_rdata`=16'h0505.
  - ACK clears `interrupt` and status = 16'h0100.
- Read 0x5510 on a cycle with `sample_valid`=1 followed by one idle sample cycle:
  - Sample written first.
  - Read returns `{8'h10, data}` at latency 3.
- Two reads back-to-back under continuous `sample_valid`:
  - Second read dropped (no response), status `rd_drop`=1.
  - START clears it.
- Assert `rst`=0 mid-capture at `count`=100:
  - All outputs 0 immediately, state IDLE, `count`=0.
  - Samples ignored until a new START.
